// File: rtl/layer_frame_feeder_pkg.sv
// Shared constants, state encoding and bus slicing helper for the layer frame feeders.
package layer_frame_feeder_pkg;

    localparam int DW           = 16;
    localparam int N_IN         = 15;
    localparam int NODE_LAT_DEF = 3;
    localparam int IDX_W        = $clog2(N_IN);
    localparam int LEN_W        = $clog2(N_IN + 1);
    localparam int BUS_W        = N_IN * DW;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FILL  = 2'd1,
        STALL = 2'd2
    } feed_state_t;

    // LSB position of activation slice i on the parallel frame bus
    function automatic int slice_lsb(input int i);
        return i * DW;
    endfunction

endpackage

// File: rtl/layer_frame_feeder_if.sv
// Activation stream in, parallel frame and result timing out.
// Stream handshake: a word transfers on a rising edge where s_valid && s_ready;
// s_valid/s_data/s_last hold until that edge, s_ready never depends on s_valid.
interface layer_frame_feeder_if;
    import layer_frame_feeder_pkg::*;

    logic             s_valid;
    logic [DW-1:0]    s_data;
    logic             s_last;
    logic             s_ready;
    logic [BUS_W-1:0] a_bus;
    logic             frame_stb;
    logic             res_valid;
    logic             err_len;
    logic             busy;

    modport master (
        output s_valid, s_data, s_last,
        input  s_ready, a_bus, frame_stb, res_valid, err_len, busy
    );

    modport slave (
        input  s_valid, s_data, s_last,
        output s_ready, a_bus, frame_stb, res_valid, err_len, busy
    );

endinterface

// File: rtl/layer_frame_feeder_frame_shadow_buf.sv
// Shadow frame storage: indexed word writes, zero-filled parallel view of a closing
// frame (including the word written this cycle) or of a frame held back for later issue.
module frame_shadow_buf
    import layer_frame_feeder_pkg::*;
(
    input  logic             clk,
    input  logic             reset,
    input  logic             wr_en,
    input  logic [IDX_W-1:0] wr_idx,
    input  logic [DW-1:0]    wr_data,
    input  logic             close,
    input  logic             use_held,
    output logic [BUS_W-1:0] frame
);

    logic [DW-1:0]    mem [N_IN];
    logic [LEN_W-1:0] held_len;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < N_IN; i++) begin
                mem[i] <= '0;
            end
            held_len <= '0;
        end else begin
            if (wr_en) begin
                mem[wr_idx] <= wr_data;
            end
            if (wr_en && close) begin
                held_len <= LEN_W'(wr_idx) + LEN_W'(1);
            end
        end
    end

    // Slices past the frame length read as zero; stale words beyond it are never exposed
    always_comb begin
        frame = '0;
        for (int i = 0; i < N_IN; i++) begin
            if (use_held) begin
                if (LEN_W'(i) < held_len) begin
                    frame[slice_lsb(i) +: DW] = mem[i];
                end
            end else begin
                if (LEN_W'(i) < LEN_W'(wr_idx)) begin
                    frame[slice_lsb(i) +: DW] = mem[i];
                end else if (LEN_W'(i) == LEN_W'(wr_idx)) begin
                    frame[slice_lsb(i) +: DW] = wr_data;
                end
            end
        end
    end

endmodule

// File: rtl/layer_frame_feeder.sv
// Packs the activation stream into N_IN-wide frames for the node array and flags
// the cycle in which the node outputs for each frame become valid.
module layer_frame_feeder
    import layer_frame_feeder_pkg::*;
#(
    parameter int NODE_LAT = NODE_LAT_DEF
) (
    input  logic                 clk,
    input  logic                 reset,
    layer_frame_feeder_if.slave  fb,
    output feed_state_t          dbg_state
);

    localparam int LAT_W = $clog2(NODE_LAT + 1);

    feed_state_t      state;
    logic [IDX_W-1:0] idx;
    logic [IDX_W-1:0] idx_n;
    logic [LAT_W-1:0] lat;
    logic             pending;
    logic             busy_n;
    logic             accept;
    logic             last_slot;
    logic             close;
    logic             lat_done;
    logic             pend_set;
    logic             issue_held;
    logic             issue;
    logic [BUS_W-1:0] frame;

    assign fb.s_ready = !pending;
    assign dbg_state  = state;

    assign accept     = fb.s_valid && fb.s_ready;
    assign last_slot  = (idx == IDX_W'(N_IN - 1));
    assign close      = accept && (fb.s_last || last_slot);
    assign lat_done   = (lat == LAT_W'(1));
    // A frame closing while the previous result is still more than one edge away is held
    assign pend_set   = close && fb.busy && !lat_done;
    assign issue_held = pending && lat_done;
    assign issue      = (close && !pend_set) || issue_held;

    always_comb begin
        idx_n  = idx;
        busy_n = fb.busy;
        if (close) begin
            idx_n = '0;
        end else if (accept) begin
            idx_n = idx + IDX_W'(1);
        end
        if (issue) begin
            busy_n = 1'b1;
        end else if (lat_done) begin
            busy_n = 1'b0;
        end
    end

    frame_shadow_buf u_shadow (
        .clk      (clk),
        .reset    (reset),
        .wr_en    (accept),
        .wr_idx   (idx),
        .wr_data  (fb.s_data),
        .close    (close),
        .use_held (issue_held),
        .frame    (frame)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state        <= IDLE;
            idx          <= '0;
            lat          <= '0;
            pending      <= 1'b0;
            fb.a_bus     <= '0;
            fb.frame_stb <= 1'b0;
            fb.res_valid <= 1'b0;
            fb.err_len   <= 1'b0;
            fb.busy      <= 1'b0;
        end else begin
            idx          <= idx_n;
            fb.busy      <= busy_n;
            fb.frame_stb <= issue;
            fb.res_valid <= lat_done;
            if (issue) begin
                fb.a_bus <= frame;
                lat      <= LAT_W'(NODE_LAT);
            end else if (lat != '0) begin
                lat <= lat - LAT_W'(1);
            end
            if (pend_set) begin
                pending <= 1'b1;
            end else if (issue_held) begin
                pending <= 1'b0;
            end
            // Early s_last, or a full frame without s_last, marks a length error
            if (close && (fb.s_last != last_slot)) begin
                fb.err_len <= 1'b1;
            end
            case (state)
                IDLE:    if (accept) state <= FILL;
                FILL: begin
                    if (pend_set) begin
                        state <= STALL;
                    end else if (!busy_n && idx_n == '0) begin
                        state <= IDLE;
                    end
                end
                STALL:   if (issue_held) state <= FILL;
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_layer_frame_feeder.sv
// Directed-plus-random bench for layer_frame_feeder with a transaction-level timing model.
module tb_layer_frame_feeder;
  import layer_frame_feeder_pkg::*;

  localparam int W    = BUS_W;
  localparam int LAT0 = 3;
  localparam int LAT1 = 20;

  // clock / reset
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  layer_frame_feeder_if if0 ();
  layer_frame_feeder_if if1 ();
  feed_state_t st0, st1;

  layer_frame_feeder #(.NODE_LAT(LAT0)) dut0 (.clk(clk), .reset(rst_n), .fb(if0), .dbg_state(st0));
  layer_frame_feeder #(.NODE_LAT(LAT1)) dut1 (.clk(clk), .reset(rst_n), .fb(if1), .dbg_state(st1));

  // scoreboard
  typedef struct { int inst; logic [W-1:0] bus; int stb_cyc; } frame_exp_t;
  typedef struct { int inst; int res_cyc; } res_exp_t;
  frame_exp_t frame_q[$];
  res_exp_t   res_q[$];
  int n_vec = 0;
  int n_fail = 0;

  // reference model: frame boundaries, issue edge = max(close edge, previous result edge)
  int            cnt[2];
  logic [DW-1:0] words[2][N_IN];
  int            last_res[2];
  int            pend_lo[2];
  int            pend_hi[2];
  logic          exp_err[2];
  logic [W-1:0]  cur_bus[2];
  int            lat_of[2];

  task automatic chk(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    for (int k = 0; k < 2; k++) begin
      cnt[k] = 0; last_res[k] = 0; pend_lo[k] = 0; pend_hi[k] = 0;
      exp_err[k] = 1'b0; cur_bus[k] = '0;
    end
    frame_q.delete();
    res_q.delete();
  endtask

  task automatic model_accept(input int k, input logic [DW-1:0] d, input logic l, input int e);
    logic [W-1:0] b;
    int issue;
    words[k][cnt[k]] = d;
    cnt[k]++;
    if (l || cnt[k] == N_IN) begin
      b = '0;
      for (int i = 0; i < cnt[k]; i++) b[i*DW +: DW] = words[k][i];
      if (l != (cnt[k] == N_IN)) exp_err[k] = 1'b1;
      issue = (last_res[k] > e) ? last_res[k] : e;
      if (issue > e) begin
        pend_lo[k] = e;
        pend_hi[k] = issue;
      end
      last_res[k] = issue + lat_of[k];
      frame_q.push_back('{k, b, issue});
      res_q.push_back('{k, last_res[k]});
      cnt[k] = 0;
    end
  endtask

  // driver tasks
  task automatic drive(input int k, input logic v, input logic [DW-1:0] d, input logic l);
    if (k == 0) begin
      if0.s_valid = v; if0.s_data = d; if0.s_last = l;
    end else begin
      if1.s_valid = v; if1.s_data = d; if1.s_last = l;
    end
  endtask

  function automatic logic rdy(input int k);
    return (k == 0) ? if0.s_ready : if1.s_ready;
  endfunction

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic send(input int k, input logic [DW-1:0] d, input logic l);
    int g = 0;
    drive(k, 1'b1, d, l);
    while (rdy(k) !== 1'b1 && g < 300) begin
      @(posedge clk); #1;
      g++;
    end
    if (g >= 300) chk("ready_timeout", rdy(k), 1);
    @(posedge clk); #1;
    model_accept(k, d, l, cyc);
    drive(k, 1'b0, '0, 1'b0);
  endtask

  task automatic chk_reset(input int k);
    if (k == 0) begin
      chk("rst_a_bus0", if0.a_bus, 0);     chk("rst_stb0", if0.frame_stb, 0);
      chk("rst_res0", if0.res_valid, 0);   chk("rst_err0", if0.err_len, 0);
      chk("rst_busy0", if0.busy, 0);       chk("rst_ready0", if0.s_ready, 1);
    end else begin
      chk("rst_a_bus1", if1.a_bus, 0);     chk("rst_stb1", if1.frame_stb, 0);
      chk("rst_res1", if1.res_valid, 0);   chk("rst_err1", if1.err_len, 0);
      chk("rst_busy1", if1.busy, 0);       chk("rst_ready1", if1.s_ready, 1);
    end
  endtask

  // output monitor, sampled on the falling edge
  always @(negedge clk) begin
    for (int k = 0; k < 2; k++) begin
      logic stb, res, rd, er, bz;
      logic [W-1:0] bus;
      int fi;
      stb = (k == 0) ? if0.frame_stb : if1.frame_stb;
      res = (k == 0) ? if0.res_valid : if1.res_valid;
      rd  = (k == 0) ? if0.s_ready   : if1.s_ready;
      er  = (k == 0) ? if0.err_len   : if1.err_len;
      bz  = (k == 0) ? if0.busy      : if1.busy;
      bus = (k == 0) ? if0.a_bus     : if1.a_bus;
      if (stb === 1'b1) begin
        fi = -1;
        foreach (frame_q[j]) if (fi < 0 && frame_q[j].inst == k) fi = j;
        if (fi < 0) chk($sformatf("stb_unexpected[%0d]", k), stb, 0);
        else begin
          chk($sformatf("a_bus_on_stb[%0d]", k), bus, frame_q[fi].bus);
          chk($sformatf("stb_cycle[%0d]", k), cyc, frame_q[fi].stb_cyc);
          cur_bus[k] = frame_q[fi].bus;
          frame_q.delete(fi);
        end
      end
      if (res === 1'b1) begin
        fi = -1;
        foreach (res_q[j]) if (fi < 0 && res_q[j].inst == k) fi = j;
        if (fi < 0) chk($sformatf("res_unexpected[%0d]", k), res, 0);
        else begin
          chk($sformatf("res_cycle[%0d]", k), cyc, res_q[fi].res_cyc);
          res_q.delete(fi);
        end
      end
      chk($sformatf("a_bus_hold[%0d]", k), bus, cur_bus[k]);
      chk($sformatf("s_ready[%0d]", k), rd, !(cyc >= pend_lo[k] && cyc < pend_hi[k]));
      chk($sformatf("err_len[%0d]", k), er, exp_err[k]);
      chk($sformatf("busy[%0d]", k), bz, cyc < last_res[k]);
    end
  end

  // directed steps
  initial begin
    int len;
    logic lst;
    lat_of[0] = LAT0;
    lat_of[1] = LAT1;
    model_reset();
    drive(0, 1'b0, '0, 1'b0);
    drive(1, 1'b0, '0, 1'b0);
    rst_n = 1'b0;
    idle(3);
    chk_reset(0);
    chk_reset(1);
    rst_n = 1'b1;
    idle(2);

    // partial frame discarded by reset
    for (int i = 0; i < 7; i++) send(0, DW'($urandom), 1'b0);
    rst_n = 1'b0;
    model_reset();
    #1;
    chk_reset(0);
    idle(2);
    rst_n = 1'b1;

    // words 1..15 with s_last on the 15th
    for (int i = 1; i <= 15; i++) send(0, DW'(i), i == 15);
    idle(6);

    // early s_last on the 5th word
    for (int i = 0; i < 5; i++) send(0, DW'(16'h0100 + i), i == 4);
    idle(5);

    // 16 words without s_last, then the next frame completes normally
    for (int i = 0; i < 16; i++) send(0, DW'($urandom), 1'b0);
    for (int i = 0; i < 14; i++) send(0, DW'($urandom), i == 13);
    idle(5);

    // two frames back-to-back at full rate
    repeat (2) for (int i = 0; i < 15; i++) send(0, DW'($urandom), i == 14);
    idle(5);

    // random lengths and gaps
    repeat (8) begin
      len = $urandom_range(1, 15);
      lst = (len < 15) ? 1'b1 : 1'($urandom_range(0, 1));
      for (int i = 0; i < len; i++) send(0, DW'($urandom), (i == len - 1) && lst);
      idle($urandom_range(0, 3));
    end

    // long node latency: frames pend behind the previous result
    repeat (3) for (int i = 0; i < 15; i++) send(1, DW'($urandom), i == 14);
    idle(70);

    chk("frames_left", frame_q.size(), 0);
    chk("results_left", res_q.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule

// File: doc/layer_frame_feeder.md
# layer_frame_feeder

Upstream driver for a fully-connected layer of neuron nodes. Accepts a serial stream of 16-bit activations (valid/ready) from the previous layer or sample front end, packs them into a 15-wide activation frame, and presents the frame to the node array as a stable parallel bus. It then waits out the node pipeline latency and flags the cycle in which the node outputs (N*x) are valid. While a frame is being evaluated, the next frame fills a shadow buffer, so the nodes see a new frame every N_IN cycles at full stream rate.

## Interface
- N_IN, 15, activations per frame (node fan-in)
- DW, 16, activation width (two's complement, same format as node inputs)
- NODE_LAT, 3, clock edges from bus update to valid node output (input capture, weighted sum, ReLU register)
- clk  in  1  single clock, all logic on rising edge
- reset  in  1  asynchronous, active-low; clears all state
- s_valid  in  1  stream word valid
- s_data  in  DW  activation word
- s_last  in  1  marks final word of a frame
- s_ready  out  1  feeder can accept a word this cycle
- a_bus  out  N_IN*DW  frame to nodes; slice i (bits i*DW +: DW) drives A{i}x
- frame_stb  out  1  one-cycle pulse: a_bus updated at this edge
- res_valid  out  1  one-cycle pulse: node outputs valid this cycle
- err_len  out  1  sticky: frame length differed from N_IN
- busy  out  1  a frame is in the node pipeline

## Operation
- Shadow buffer (N_IN x DW) and word index idx (0..N_IN-1). A word is accepted when s_valid && s_ready and written to shadow[idx]; idx then increments.
- Frame closes on an accepted word with s_last=1 or idx=N_IN-1, whichever comes first.
  - Early s_last (idx < N_IN-1): remaining slices are zero-filled; set err_len.
  - idx=N_IN-1 without s_last: frame closes; set err_len. Words after that start a new frame.
- On close: a_bus <= shadow (with zero fill), frame_stb=1, idx <= 0, latency counter lat <= NODE_LAT, busy=1. a_bus holds until the next close.
- lat decrements each cycle while nonzero. Edge at which lat goes 1->0 asserts res_valid for one cycle and clears busy, unless a new close occurs at the same edge.
- s_ready = !(pending_full). pending_full is set when a frame closes while busy is still high (the result of the previous frame is not yet out); it clears when that result's res_valid fires, which also issues the pending frame. With N_IN >= NODE_LAT at full rate, pending_full never sets.
- States: IDLE (idx=0, !busy), FILL (idx>0 or busy), STALL (pending_full). IDLE->FILL on first accepted word; FILL->STALL on close while busy; STALL->FILL on res_valid; FILL->IDLE when !busy and idx=0.
- err_len clears only on reset.

## Timing
- Reset values: s_ready=1, a_bus=0, frame_stb=0, res_valid=0, err_len=0, busy=0; idx=0, lat=0, shadow=0, pending cleared. Reset mid-frame discards the partial frame and any in-flight result (no res_valid).
- Close edge E: a_bus and frame_stb valid in the cycle after E. res_valid is high in the cycle after edge E+NODE_LAT.
- Back-to-back: 15 words at 1 word/cycle -> frame_stb every 15 cycles, res_valid every 15 cycles, s_ready stays 1.
- Simultaneous close and res_valid at the same edge: both take effect; busy stays 1 and lat reloads.
- s_data is not modified; the nodes apply sign and ReLU themselves.

## Structure
- Shared package: DW, N_IN, NODE_LAT defaults; state enum (IDLE, FILL, STALL); bus slice index helper.
- One sub-module: frame_shadow_buf (indexed write, zero-fill on close, parallel read), which is reused by other layer feeders.
- Counter/FSM and handshake in the top.

## Test plan
- Reset low mid-stream after 7 words -> all outputs at reset values; next 15 words (1..15) -> a_bus slice i = i+1; frame_stb once, no err_len.
- 15 words 0x0001..0x000F with s_last on the 15th -> frame_stb at edge E, res_valid exactly at the cycle after E+3, a_bus stable until the next close.
- s_last on the 5th word (values 0x0100..0x0104) -> slices 0..4 hold data, slices 5..14 = 0, err_len=1 and it stays 1 across later good frames.
- 16 words with no s_last -> frame closes on the 15th with err_len=1; the 16th word is slice 0 of the next frame.
- Two frames back-to-back at full rate -> s_ready never drops, frame_stb and res_valid each pulse twice, 15 cycles apart.
- With NODE_LAT=20 override, two consecutive frames -> s_ready low from the second close until the first res_valid; second frame_stb follows that res_valid; no word lost or duplicated.
